// File: rtl/pc_cu.sv
// Fetch-side PC control: owns the PC, applies stage-4 redirects, sequences interrupt entry
// (drain, push return PC, vector) and holds the interrupt-enable flag.
module pc_cu #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] ISR_VECTOR   = 32'h0000_03FC,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch_s,
    input  logic        jump,
    input  logic        jr,
    input  logic        reti,
    input  logic [31:0] PC_in,
    input  logic        stall,
    input  logic        intr,
    input  logic        ie_set,
    input  logic        ie_clr,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        flush,
    output logic        bubble,
    output logic        int_push,
    output logic [31:0] int_pc,
    output logic        intr_ack,
    output logic        IE
);

    localparam int unsigned     CntW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDrain, StPush} state_e;

    state_e          state_q;
    logic [31:0]     pc_q;
    logic [31:0]     int_pc_q;
    logic [CntW-1:0] cnt_q;
    logic            ie_q;

    logic redirect;
    logic int_entry;
    logic push_ok;

    assign redirect  = Branch_s | jump | jr | reti;
    assign int_entry = (state_q == StRun) & ~redirect & intr & ie_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            int_pc_q <= '0;
            cnt_q    <= '0;
            ie_q     <= 1'b0;
        end else begin
            if (reti | ie_set) begin
                ie_q <= 1'b1;
            end else if (int_entry | ie_clr) begin
                ie_q <= 1'b0;
            end

            case (state_q)
                StRun: begin
                    if (redirect) begin
                        pc_q <= PC_in;
                    end else if (int_entry) begin
                        state_q  <= StDrain;
                        cnt_q    <= CntInit;
                        int_pc_q <= pc_q;
                    end else if (!stall) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                StDrain: begin
                    // A redirect retargets the saved return PC and restarts the drain.
                    if (redirect) begin
                        pc_q     <= PC_in;
                        int_pc_q <= PC_in;
                        cnt_q    <= CntInit;
                    end else if (cnt_q == '0) begin
                        state_q <= StPush;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StPush: begin
                    if (redirect) begin
                        state_q  <= StDrain;
                        pc_q     <= PC_in;
                        int_pc_q <= PC_in;
                        cnt_q    <= CntInit;
                    end else begin
                        state_q <= StRun;
                        pc_q    <= ISR_VECTOR;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // The push is squashed if the same cycle is overridden by reset or a redirect.
    assign push_ok  = (state_q == StPush) & ~redirect & ~rst;

    assign PC       = pc_q;
    assign PC4      = pc_q + 32'd4;
    assign flush    = redirect;
    assign bubble   = (state_q != StRun);
    assign int_push = push_ok;
    assign intr_ack = push_ok;
    assign int_pc   = int_pc_q;
    assign IE       = ie_q;

endmodule

// File: tb/tb_pc_cu.sv
// Bench for pc_cu: directed scenarios plus random traffic, scored against a behavioural model
// through an expectation queue drained by an independent monitor.
module tb_pc_cu;

    localparam logic [31:0] ResetPc   = 32'h0000_0000;
    localparam logic [31:0] IsrVector = 32'h0000_03FC;
    localparam int          Drain     = 3;

    logic        clk = 1'b0;
    logic        rst, Branch_s, jump, jr, reti, stall, intr, ie_set, ie_clr;
    logic [31:0] PC_in;
    logic [31:0] PC, PC4, int_pc;
    logic        flush, bubble, int_push, intr_ack, IE;

    pc_cu #(
        .RESET_PC    (ResetPc),
        .ISR_VECTOR  (IsrVector),
        .DRAIN_CYCLES(Drain)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Branch_s(Branch_s),
        .jump    (jump),
        .jr      (jr),
        .reti    (reti),
        .PC_in   (PC_in),
        .stall   (stall),
        .intr    (intr),
        .ie_set  (ie_set),
        .ie_clr  (ie_clr),
        .PC      (PC),
        .PC4     (PC4),
        .flush   (flush),
        .bubble  (bubble),
        .int_push(int_push),
        .int_pc  (int_pc),
        .intr_ack(intr_ack),
        .IE      (IE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] int_pc;
        logic        flush;
        logic        bubble;
        logic        int_push;
        logic        intr_ack;
        logic        ie;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: an entry is a run of Drain+1 bubble cycles, the last being the push.
    logic [31:0] m_pc     = ResetPc;
    logic [31:0] m_ret    = 32'h0;
    logic        m_ie     = 1'b0;
    logic        m_entry  = 1'b0;
    int          m_left   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic j, input logic jrr,
                        input logic rt, input logic [31:0] pin, input logic st,
                        input logic it, input logic s, input logic c);
        exp_t e;
        logic redir, new_ie;
        rst = r; Branch_s = b; jump = j; jr = jrr; reti = rt;
        PC_in = pin; stall = st; intr = it; ie_set = s; ie_clr = c;
        redir      = b | j | jrr | rt;
        e.pc       = m_pc;
        e.pc4      = m_pc + 32'd4;
        e.int_pc   = m_ret;
        e.flush    = redir;
        e.bubble   = m_entry;
        e.int_push = m_entry && (m_left == 1) && !redir && !r;
        e.intr_ack = e.int_push;
        e.ie       = m_ie;
        q.push_back(e);
        if (r) begin
            m_pc = ResetPc; m_ie = 1'b0; m_entry = 1'b0; m_left = 0; m_ret = 32'h0;
        end else begin
            if (rt || s) new_ie = 1'b1;
            else if ((!m_entry && !redir && it && m_ie) || c) new_ie = 1'b0;
            else new_ie = m_ie;
            if (redir) begin
                m_pc = pin;
                if (m_entry) begin
                    m_ret  = pin;
                    m_left = Drain + 1;
                end
            end else if (m_entry) begin
                if (m_left == 1) begin
                    m_pc    = IsrVector;
                    m_entry = 1'b0;
                end else begin
                    m_left--;
                end
            end else if (it && m_ie) begin
                m_entry = 1'b1;
                m_left  = Drain + 1;
                m_ret   = m_pc;
            end else if (!st) begin
                m_pc = m_pc + 32'd4;
            end
            m_ie = new_ie;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("PC", PC, e.pc);
                chk("PC4", PC4, e.pc4);
                chk("int_pc", int_pc, e.int_pc);
                chk("flush", {31'b0, flush}, {31'b0, e.flush});
                chk("bubble", {31'b0, bubble}, {31'b0, e.bubble});
                chk("int_push", {31'b0, int_push}, {31'b0, e.int_push});
                chk("intr_ack", {31'b0, intr_ack}, {31'b0, e.intr_ack});
                chk("IE", {31'b0, IE}, {31'b0, e.ie});
            end
        end
    end

    initial begin : stimulus
        logic [31:0] pin;
        int          k;
        rst = 1'b1; Branch_s = 0; jump = 0; jr = 0; reti = 0; PC_in = 0;
        stall = 0; intr = 0; ie_set = 0; ie_clr = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        idle(8);                                              // PC 0 .. 0x1C
        step(0, 1, 0, 0, 0, 32'h100, 0, 0, 0, 0);             // branch at 0x20
        idle(2);
        step(0, 0, 1, 0, 0, 32'h40, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 1, 0, 0, 32'h80, 1, 0, 0, 0);              // stall loses to jump
        idle(1);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);               // ie_set
        step(0, 0, 1, 0, 0, 32'h50, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0);               // intr at 0x50
        idle(6);
        step(0, 0, 0, 0, 1, 32'h50, 0, 0, 0, 0);              // reti
        idle(2);
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 32'h200, 1, 0, 0, 0);             // jr in 2nd drain cycle
        idle(6);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);               // reset during push
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 32'hFFFF_FFF8, 0, 0, 0, 0);       // increment wrap
        idle(3);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1);               // set beats clear
        idle(1);
        for (int i = 0; i < 2000; i++) begin
            k   = $urandom_range(0, 15);
            pin = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 63) == 0, k == 0, k == 1, k == 2, k == 3, pin,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end
        idle(1);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_queue: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
